data_mem_access_unit: RTL

Memory-access (MA) stage controller of the RV32IM pipeline, sitting between the EX/MA pipeline register and the MA/WB register. It turns load/store control from EX/MA into a request to the data memory, handling byte-lane alignment and a ready handshake. It stalls the pipeline while an access is outstanding and delivers the sign- or zero-extended load result to MA/WB. It also flags misaligned, illegal and timed-out accesses.

---
 rtl/data_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_access_unit.sv
// Memory-access stage controller for the RV32IM pipeline.
// Turns EX/MA load/store control into one word-aligned request to the data memory.
// It holds the pipeline stalled while the access is outstanding, then formats the
// load result for MA/WB. Misaligned, illegal and timed-out accesses raise access_fault.
module data_mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_out,
    input  logic [31:0] write_data,
    input  logic [31:0] mem_readdata,
    input  logic        mem_ready,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_fault
);

    // Wide enough to hold TIMEOUT; a zero TIMEOUT still needs a 1-bit counter.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        tflag_q, tflag_d;
    // Access type and byte offset of the outstanding op, needed to format the load.
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        op_present;
    logic        op_valid;
    logic        f3_load_ok;
    logic        f3_store_ok;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // Decode the EX/MA op: legal access type for its direction, and natural alignment.
    always_comb begin
        f3_load_ok  = 1'b0;
        f3_store_ok = 1'b0;
        aligned     = 1'b1;
        case (funct3)
            3'b000: begin
                f3_load_ok  = 1'b1;
                f3_store_ok = 1'b1;
            end
            3'b001: begin
                f3_load_ok  = 1'b1;
                f3_store_ok = 1'b1;
                aligned     = ~ALU_out[0];
            end
            3'b010: begin
                f3_load_ok  = 1'b1;
                f3_store_ok = 1'b1;
                aligned     = (ALU_out[1:0] == 2'b00);
            end
            3'b100: begin
                f3_load_ok  = 1'b1;
            end
            3'b101: begin
                f3_load_ok  = 1'b1;
                aligned     = ~ALU_out[0];
            end
            default: begin
                f3_load_ok  = 1'b0;
                f3_store_ok = 1'b0;
            end
        endcase
        op_present = mem_read | mem_write;
        op_valid   = (mem_read & ~mem_write & f3_load_ok & aligned) |
                     (mem_write & ~mem_read & f3_store_ok & aligned);
    end

    // Store lane steering: replicate the datum across the word and enable the addressed lanes.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = '0;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << ALU_out[1:0];
                    wdata_new = {4{write_data[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << {ALU_out[1], 1'b0};
                    wdata_new = {2{write_data[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = write_data;
                end
            endcase
        end
    end

    // Load formatting: pick the addressed byte/halfword of the returned word and extend it.
    always_comb begin
        case (addr_lo_q)
            2'b00:   byte_sel = mem_readdata[7:0];
            2'b01:   byte_sel = mem_readdata[15:8];
            2'b10:   byte_sel = mem_readdata[23:16];
            default: byte_sel = mem_readdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'b0, byte_sel};
            3'b101:  load_fmt = {16'b0, half_sel};
            default: load_fmt = mem_readdata;
        endcase
    end

    // Next-state logic for the IDLE -> ACCESS -> DONE sequence and its registered outputs.
    always_comb begin
        state_d   = state_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        tflag_d   = tflag_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    state_d   = StAccess;
                    rd_req_d  = mem_read;
                    wr_req_d  = mem_write;
                    addr_d    = {ALU_out[31:2], 2'b00};
                    wdata_d   = wdata_new;
                    be_d      = be_new;
                    funct3_d  = funct3;
                    addr_lo_d = ALU_out[1:0];
                    cnt_d     = '0;
                end else if (op_present) begin
                    // Rejected op: hand MA/WB a clean zero rather than a stale load.
                    rdata_d = '0;
                end
            end
            StAccess: begin
                if (mem_ready) begin
                    if (rd_req_q) begin
                        rdata_d = load_fmt;
                    end
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_d == TimeoutCnt)) begin
                        rd_req_d = 1'b0;
                        wr_req_d = 1'b0;
                        rdata_d  = '0;
                        tflag_d  = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                // EX/MA still shows the finished op here; it is ignored so it cannot retrigger.
                state_d = StIdle;
                tflag_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything, dropping requests immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            tflag_q   <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            tflag_q   <= tflag_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    // Stall and fault are combinational so the pipeline reacts in the detecting cycle.
    always_comb begin
        stall        = ((state_q == StIdle) & op_valid) | (state_q == StAccess);
        access_fault = ((state_q == StIdle) & op_present & ~op_valid) |
                       ((state_q == StDone) & tflag_q);
    end

    assign mem_read_req   = rd_req_q;
    assign mem_write_req  = wr_req_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = be_q;
    assign read_data      = rdata_q;

endmodule
